seq_shift_add_mul: RTL and testbench

//   Multi-cycle parametrised shift-add multiplier with start/done handshake; one multiplier bit per clock.

---
 rtl/seq_shift_add_mul.sv | 122 ++++++++++++
 tb/tb_seq_shift_add_mul.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-add multiplier. It retires one multiplier bit per clock, works in
// unsigned or two's-complement mode per operation, and registers a 2*WIDTH product with a done pulse.
module seq_shift_add_mul #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 neg_q, neg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shifted;

    // The most negative operand negates to itself. Read as unsigned, that is the correct magnitude.
    always_comb begin
        abs_a = multiplicand;
        abs_b = multiplier;
        if (signed_mode && multiplicand[WIDTH-1]) begin
            abs_a = -multiplicand;
        end
        if (signed_mode && multiplier[WIDTH-1]) begin
            abs_b = -multiplier;
        end
    end

    // The add carry goes into the top bit of the shifted pair, so no bit is lost.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
        shifted = {sum, lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = abs_a;
                    hi_d    = '0;
                    lo_d    = abs_b;
                    neg_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                hi_d  = shifted[2*WIDTH-1:WIDTH];
                lo_d  = shifted[WIDTH-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    product_d = neg_q ? -shifted : shifted;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Testbench for seq_shift_add_mul. It exercises a 16-bit and an 8-bit instance with directed corner cases
// and random operations, and checks them against an integer-arithmetic reference model.
module tb_seq_shift_add_mul;

    logic        clock;
    logic        reset;

    logic        start16, signedMode16;
    logic [15:0] mcand16, mplier16;
    logic        ready16, busy16, done16;
    logic [31:0] product16;

    logic        start8, signedMode8;
    logic [7:0]  mcand8, mplier8;
    logic        ready8, busy8, done8;
    logic [15:0] product8;

    int total;
    int bad;

    seq_shift_add_mul #(.WIDTH(16)) dut16 (
        .clk(clock), .rst(reset), .start(start16), .signed_mode(signedMode16),
        .multiplicand(mcand16), .multiplier(mplier16),
        .ready(ready16), .busy(busy16), .done(done16), .product(product16)
    );

    seq_shift_add_mul #(.WIDTH(8)) dut8 (
        .clk(clock), .rst(reset), .start(start8), .signed_mode(signedMode8),
        .multiplicand(mcand8), .multiplier(mplier8),
        .ready(ready8), .busy(busy8), .done(done8), .product(product8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // This is the reference product. Operands are read as integers of width w,
    // multiplied as plain integers, and the result is truncated to 2*w bits.
    function automatic longint refMul(input int w, input logic sm, input longint a, input longint b);
        longint r;
        if (sm && a[w-1]) a = a - (longint'(1) << w);
        if (sm && b[w-1]) b = b - (longint'(1) << w);
        r = a * b;
        return r & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic waitDone16(output int cyc);
        cyc = 0;
        do begin
            @(posedge clock); #1;
            cyc++;
        end while (!done16 && cyc < 40);
    endtask

    // This runs one 16-bit operation. When noisy is set, it toggles start and the operand inputs
    // while the operation runs; the DUT must ignore them.
    task automatic applyStimulus(input logic sm, input logic [15:0] a, input logic [15:0] b,
                                 input longint exp, input bit noisy);
        logic [31:0] prevProd;
        bit          moved;
        int          cyc;
        checkOutput("ready_before_start", ready16, 1);
        prevProd     = product16;
        moved        = 0;
        signedMode16 = sm;
        mcand16      = a;
        mplier16     = b;
        start16      = 1'b1;
        @(posedge clock); #1;
        start16 = 1'b0;
        checkOutput("busy_after_accept", busy16, 1);
        cyc = 0;
        while (!done16 && cyc < 40) begin
            if (noisy) begin
                start16      = 1'($urandom_range(0, 1));
                mcand16      = 16'($urandom);
                mplier16     = 16'($urandom);
                signedMode16 = 1'($urandom_range(0, 1));
            end
            @(posedge clock); #1;
            cyc++;
            if (!done16 && product16 !== prevProd) moved = 1;
        end
        start16 = 1'b0;
        checkOutput("latency", cyc, 16);
        checkOutput("product_held_in_run", moved, 0);
        checkOutput("product", product16, exp);
        checkOutput("ready_with_done", ready16, 1);
        @(posedge clock); #1;
        checkOutput("done_single_pulse", done16, 0);
        checkOutput("product_after_done", product16, exp);
    endtask

    task automatic applyStimulus8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                                  input longint exp);
        int cyc;
        checkOutput("w8_ready", ready8, 1);
        signedMode8 = sm;
        mcand8      = a;
        mplier8     = b;
        start8      = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        cyc    = 0;
        while (!done8 && cyc < 30) begin
            @(posedge clock); #1;
            cyc++;
        end
        checkOutput("w8_latency", cyc, 8);
        checkOutput("w8_product", product8, exp);
        @(posedge clock); #1;
        checkOutput("w8_done_single_pulse", done8, 0);
    endtask

    initial begin
        int          cyc;
        int          doneCount;
        logic        sm;
        logic [15:0] a16, b16;
        logic [7:0]  a8, b8;
        logic [15:0] corners [4];

        total = 0;
        bad   = 0;
        corners[0] = 16'h0000;
        corners[1] = 16'h8000;
        corners[2] = 16'hFFFF;
        corners[3] = 16'h7FFF;

        reset = 1'b1;
        start16 = 1'b0; signedMode16 = 1'b0; mcand16 = '0; mplier16 = '0;
        start8  = 1'b0; signedMode8  = 1'b0; mcand8  = '0; mplier8  = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_ready", ready16, 1);
        checkOutput("reset_busy", busy16, 0);
        checkOutput("reset_done", done16, 0);
        checkOutput("reset_product", product16, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        $display("[TB] directed 16-bit cases");
        applyStimulus(1'b0, 16'hFFFF, 16'hFFFF, 64'hFFFE0001, 0);
        applyStimulus(1'b1, 16'hFFFD, 16'h0005, 64'hFFFFFFF1, 0);
        applyStimulus(1'b1, 16'h8000, 16'h8000, 64'h40000000, 0);
        applyStimulus(1'b0, 16'h8000, 16'h8000, 64'h40000000, 0);
        applyStimulus(1'b1, 16'h8000, 16'h7FFF, 64'hC0008000, 1);
        applyStimulus(1'b0, 16'h0000, 16'h0000, 64'h0, 1);

        $display("[TB] back-to-back with start held high");
        signedMode16 = 1'b0; mcand16 = 16'h0000; mplier16 = 16'h1234; start16 = 1'b1;
        @(posedge clock); #1;
        waitDone16(cyc);
        checkOutput("b2b_latency_first", cyc, 16);
        checkOutput("b2b_product_first", product16, 0);
        mcand16 = 16'd7; mplier16 = 16'd9;
        waitDone16(cyc);
        checkOutput("b2b_spacing", cyc, 17);
        checkOutput("b2b_product_second", product16, 64'h3F);
        start16 = 1'b0;
        @(posedge clock); #1;

        $display("[TB] reset in the middle of a run");
        signedMode16 = 1'b0; mcand16 = 16'h1234; mplier16 = 16'h5678; start16 = 1'b1;
        @(posedge clock); #1;
        start16 = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_product", product16, 0);
        checkOutput("midrst_ready", ready16, 1);
        checkOutput("midrst_done", done16, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        doneCount = 0;
        repeat (25) begin
            @(posedge clock); #1;
            if (done16) doneCount++;
        end
        checkOutput("midrst_no_done", doneCount, 0);
        checkOutput("midrst_ready_after", ready16, 1);
        applyStimulus(1'b0, 16'd2, 16'd3, 64'h6, 0);

        $display("[TB] directed 8-bit cases");
        applyStimulus8(1'b0, 8'hFF, 8'hFF, 64'hFE01);
        applyStimulus8(1'b1, 8'h80, 8'h7F, 64'hC080);
        applyStimulus8(1'b1, 8'h80, 8'h80, 64'h4000);

        $display("[TB] random 16-bit operations");
        for (int i = 0; i < 300; i++) begin
            sm  = 1'($urandom_range(0, 1));
            a16 = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            b16 = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            applyStimulus(sm, a16, b16, refMul(16, sm, longint'(a16), longint'(b16)), 1);
        end

        $display("[TB] random 8-bit operations");
        for (int i = 0; i < 150; i++) begin
            sm = 1'($urandom_range(0, 1));
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            applyStimulus8(sm, a8, b8, refMul(8, sm, longint'(a8), longint'(b8)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
